// File: rtl/sdram_pkg.sv
// Shared definitions for the SDRAM arbiter slice: FSM encodings, SDRAM command
// words {cs_n,ras_n,cas_n,we_n} and default bus widths.
package sdram_pkg;

  typedef enum logic [3:0] {
    S_INIT   = 4'b0001,
    S_ARBIT  = 4'b0010,
    S_AREF   = 4'b0100,
    S_ACCESS = 4'b1000
  } arb_state_t;

  localparam logic [3:0] CMD_NOP  = 4'b0111;
  localparam logic [3:0] CMD_PRE  = 4'b0010;
  localparam logic [3:0] CMD_AREF = 4'b0001;
  localparam logic [3:0] CMD_MRS  = 4'b0000;
  localparam logic [3:0] CMD_ACT  = 4'b0011;
  localparam logic [3:0] CMD_WR   = 4'b0100;
  localparam logic [3:0] CMD_RD   = 4'b0101;

  localparam int SDRAM_ADDR_W = 12;
  localparam int SDRAM_BANK_W = 2;
  localparam int SDRAM_DQ_W   = 16;

  // Grant index width; a single channel still gets a 1-bit index.
  function automatic int gid_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sdram_arbiter_if.sv
// Per-channel access-engine bus of the SDRAM arbiter; channel i occupies slice i
// of every packed field. master = arbiter side, slave = access-engine side.
interface sdram_arbiter_if
  import sdram_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int ADDR_W = SDRAM_ADDR_W,
  parameter int BANK_W = SDRAM_BANK_W,
  parameter int DQ_W   = SDRAM_DQ_W
);
  localparam int GID_W = gid_width(NUM_CH);

  logic [NUM_CH-1:0]        ch_ask;
  logic [NUM_CH-1:0]        ch_end;
  logic [4*NUM_CH-1:0]      ch_cmd;
  logic [ADDR_W*NUM_CH-1:0] ch_addr;
  logic [BANK_W*NUM_CH-1:0] ch_bank;
  logic [DQ_W*NUM_CH-1:0]   ch_wdata;
  logic [NUM_CH-1:0]        ch_dq_oe;
  logic [NUM_CH-1:0]        ch_en;
  logic [DQ_W-1:0]          rd_data;
  logic [GID_W-1:0]         grant_id;

  modport master (
    input  ch_ask, ch_end, ch_cmd, ch_addr, ch_bank, ch_wdata, ch_dq_oe,
    output ch_en, rd_data, grant_id
  );

  modport slave (
    output ch_ask, ch_end, ch_cmd, ch_addr, ch_bank, ch_wdata, ch_dq_oe,
    input  ch_en, rd_data, grant_id
  );

endinterface

// File: rtl/sdram_rr_sel.sv
// Channel selector: ask vector + last grant -> valid + index.
// SDRAM_ARB_RR_EN defined: round-robin from last+1; undefined: lowest index wins.
module sdram_rr_sel
  import sdram_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int GID_W  = gid_width(NUM_CH)
) (
  input  logic [NUM_CH-1:0] ask,
  input  logic [GID_W-1:0]  last,
  output logic              sel_valid,
  output logic [GID_W-1:0]  sel_idx
);

`ifdef SDRAM_ARB_RR_EN
  // Rotating search starting just after the previous winner, wrapping at NUM_CH.
  always_comb begin
    int  pos_s;
    logic hit_s;
    sel_valid = 1'b0;
    sel_idx   = '0;
    pos_s     = 0;
    hit_s     = 1'b0;
    for (int k = 1; k <= NUM_CH; k++) begin
      pos_s     = (int'(last) + k) % NUM_CH;
      hit_s     = !sel_valid && ask[pos_s];
      sel_idx   = hit_s ? GID_W'(pos_s) : sel_idx;
      sel_valid = sel_valid | hit_s;
    end
  end
`else
  logic unused_last_s;
  assign unused_last_s = ^last;

  // Downward scan so the last hit written is the lowest asking index.
  always_comb begin
    logic hit_s;
    sel_valid = 1'b0;
    sel_idx   = '0;
    hit_s     = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      hit_s     = ask[i];
      sel_idx   = hit_s ? GID_W'(i) : sel_idx;
      sel_valid = sel_valid | hit_s;
    end
  end
`endif

endmodule

// File: rtl/sdram_arbiter.sv
// SDRAM command arbiter and pin multiplexer: init, then refresh vs NUM_CH access
// engines. Optional round-robin channel selection via SDRAM_ARB_RR_EN.
module sdram_arbiter
  import sdram_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int ADDR_W = SDRAM_ADDR_W,
  parameter int BANK_W = SDRAM_BANK_W,
  parameter int DQ_W   = SDRAM_DQ_W
) (
  input  logic                sclk,
  input  logic                srst_n,
  input  logic                init_end,
  input  logic [3:0]          init_cmd,
  input  logic [ADDR_W-1:0]   init_addr,
  input  logic                aref_ask,
  input  logic                aref_end,
  input  logic [3:0]          aref_cmd,
  input  logic [ADDR_W-1:0]   aref_addr,
  output logic                aref_en,
  sdram_arbiter_if.master     bus,
  output logic                sdram_clk,
  output logic                sdram_cke,
  output logic                sdram_cs_n,
  output logic                sdram_ras_n,
  output logic                sdram_cas_n,
  output logic                sdram_we_n,
  output logic [BANK_W-1:0]   sdram_bank,
  output logic [ADDR_W-1:0]   sdram_addr,
  output logic [DQ_W/8-1:0]   sdram_dqm,
  inout  wire  [DQ_W-1:0]     sdram_dq
);

  localparam int GID_W = gid_width(NUM_CH);

  arb_state_t          state_r;
  logic [GID_W-1:0]    grant_id_r;
  logic                sel_valid_s;
  logic [GID_W-1:0]    sel_idx_s;
  logic [NUM_CH-1:0]   ch_en_s;
  logic [3:0]          cmd_s;
  logic [ADDR_W-1:0]   addr_s;
  logic [BANK_W-1:0]   bank_s;
  logic                dq_oe_s;
  logic [DQ_W-1:0]     dq_out_s;

  sdram_rr_sel #(
    .NUM_CH (NUM_CH),
    .GID_W  (GID_W)
  ) u_sel (
    .ask       (bus.ch_ask),
    .last      (grant_id_r),
    .sel_valid (sel_valid_s),
    .sel_idx   (sel_idx_s)
  );

  // Bus ownership FSM; refresh is checked before channels so it wins ties.
  always_ff @(posedge sclk or negedge srst_n) begin
    if (!srst_n) begin
      state_r    <= S_INIT;
      grant_id_r <= '0;
    end else begin
      case (state_r)
        S_INIT: begin
          if (init_end) state_r <= S_ARBIT;
        end
        S_ARBIT: begin
          if (aref_ask) begin
            state_r <= S_AREF;
          end else if (sel_valid_s) begin
            state_r    <= S_ACCESS;
            grant_id_r <= sel_idx_s;
          end
        end
        S_AREF: begin
          if (aref_end) state_r <= S_ARBIT;
        end
        S_ACCESS: begin
          if (bus.ch_end[int'(grant_id_r)]) state_r <= S_ARBIT;
        end
        default: state_r <= S_INIT;
      endcase
    end
  end

  // A pending refresh withdraws the channel enable at once so the engine wraps up its burst.
  always_comb begin
    ch_en_s = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      ch_en_s[i] = (state_r == S_ACCESS) && (int'(grant_id_r) == i) && !aref_ask;
    end
  end

  // Pin multiplexer: the current owner's command, address and bank drive the SDRAM.
  always_comb begin
    int gsel_s;
    gsel_s   = int'(grant_id_r);
    cmd_s    = CMD_NOP;
    addr_s   = '0;
    bank_s   = '0;
    dq_oe_s  = 1'b0;
    dq_out_s = bus.ch_wdata[gsel_s*DQ_W +: DQ_W];
    case (state_r)
      S_INIT: begin
        cmd_s  = init_cmd;
        addr_s = init_addr;
      end
      S_AREF: begin
        cmd_s  = aref_cmd;
        addr_s = aref_addr;
      end
      S_ACCESS: begin
        cmd_s   = bus.ch_cmd[gsel_s*4 +: 4];
        addr_s  = bus.ch_addr[gsel_s*ADDR_W +: ADDR_W];
        bank_s  = bus.ch_bank[gsel_s*BANK_W +: BANK_W];
        dq_oe_s = bus.ch_dq_oe[gsel_s];
      end
      S_ARBIT: begin
        cmd_s = CMD_NOP;
      end
      default: begin
        cmd_s = CMD_NOP;
      end
    endcase
  end

  assign aref_en      = (state_r == S_AREF);
  assign bus.ch_en    = ch_en_s;
  assign bus.grant_id = grant_id_r;
  assign bus.rd_data  = sdram_dq;

  assign sdram_clk  = ~sclk;
  assign sdram_cke  = 1'b1;
  assign sdram_dqm  = '0;
  assign {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = cmd_s;
  assign sdram_bank = bank_s;
  assign sdram_addr = addr_s;
  assign sdram_dq   = dq_oe_s ? dq_out_s : {DQ_W{1'bz}};

endmodule

// File: tb/tb_sdram_arbiter.sv
// Scoreboard bench for sdram_arbiter with NUM_CH=4; expected grant order follows
// SDRAM_ARB_RR_EN when that macro is defined.
module tb_sdram_arbiter;
  import sdram_pkg::*;

  localparam int NCH = 4;
  localparam int AW  = 12;
  localparam int BW  = 2;
  localparam int DW  = 16;

  localparam int P_CMD = 0, P_ADDR = 1, P_CHEN = 2, P_AREN = 3;
  localparam int P_RD  = 4, P_BANK = 5, P_GID  = 6, P_MISC = 7;

  logic          sclk, srst_n, init_end, aref_ask, aref_end;
  logic [3:0]    init_cmd, aref_cmd;
  logic [AW-1:0] init_addr, aref_addr;
  logic          aref_en, sdram_clk, sdram_cke;
  logic          sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n;
  logic [BW-1:0] sdram_bank;
  logic [AW-1:0] sdram_addr;
  logic [DW/8-1:0] sdram_dqm;
  wire  [DW-1:0] sdram_dq;

  sdram_arbiter_if #(.NUM_CH(NCH), .ADDR_W(AW), .BANK_W(BW), .DQ_W(DW)) bus ();

  sdram_arbiter #(.NUM_CH(NCH), .ADDR_W(AW), .BANK_W(BW), .DQ_W(DW)) dut (
    .sclk(sclk), .srst_n(srst_n), .init_end(init_end),
    .init_cmd(init_cmd), .init_addr(init_addr),
    .aref_ask(aref_ask), .aref_end(aref_end),
    .aref_cmd(aref_cmd), .aref_addr(aref_addr), .aref_en(aref_en),
    .bus(bus),
    .sdram_clk(sdram_clk), .sdram_cke(sdram_cke), .sdram_cs_n(sdram_cs_n),
    .sdram_ras_n(sdram_ras_n), .sdram_cas_n(sdram_cas_n), .sdram_we_n(sdram_we_n),
    .sdram_bank(sdram_bank), .sdram_addr(sdram_addr), .sdram_dqm(sdram_dqm),
    .sdram_dq(sdram_dq)
  );

  logic [3:0] ch_cmd_tab [NCH] = '{CMD_ACT, CMD_WR, CMD_RD, CMD_PRE};
`ifdef SDRAM_ARB_RR_EN
  int rr_seq [5] = '{2, 3, 0, 1, 2};
`else
  int rr_seq [5] = '{0, 0, 0, 0, 0};
`endif

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;

  string       q_nm [$];
  int          q_sel[$];
  int          q_cyc[$];
  logic [31:0] q_val[$];
  int          gq   [$];

  logic             prev_aref = 1'b0;
  logic [NCH-1:0]   prev_chen = '0;

  initial sclk = 1'b0;
  always #5 sclk = ~sclk;
  always @(posedge sclk) cyc <= cyc + 1;

  function automatic logic [AW-1:0] ch_addr_of(input int i);
    return AW'(256 * (i + 1) + i);
  endfunction

  function automatic logic [DW-1:0] wd_of(input int i);
    return DW'(32'hA000 + 32'h0111 * i);
  endfunction

  function automatic logic [31:0] oh(input int i);
    return 32'(1) << i;
  endfunction

  function automatic void chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    n_total++;
    if (a === e) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, a, e, $time);
  endfunction

  function automatic logic [31:0] act(input int sel);
    case (sel)
      P_CMD:  return 32'({sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n});
      P_ADDR: return 32'(sdram_addr);
      P_CHEN: return 32'(bus.ch_en);
      P_AREN: return 32'(aref_en);
      P_RD:   return 32'(bus.rd_data);
      P_BANK: return 32'(sdram_bank);
      P_GID:  return 32'(bus.grant_id);
      P_MISC: return 32'({sdram_clk, sdram_cke, sdram_dqm});
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  function automatic int owner_of(input logic [NCH-1:0] v);
    int o = 99;
    int n = 0;
    for (int i = 0; i < NCH; i++) begin
      if (v[i]) begin
        o = i;
        n++;
      end
    end
    return (n == 1) ? o : 99;
  endfunction

  task automatic expect_now(input string nm, input int sel, input logic [31:0] v);
    q_nm.push_back(nm);
    q_sel.push_back(sel);
    q_cyc.push_back(cyc);
    q_val.push_back(v);
  endtask

  task automatic step();
    @(posedge sclk);
    #1;
  endtask

  task automatic pop_grant(input int obs);
    int e;
    if (gq.size() == 0) begin
      n_total++;
      $display("FAIL grant_spurious: got owner %0d, expected no new grant (t=%0t)", obs, $time);
    end else begin
      e = gq.pop_front();
      chk("grant_order", 32'(obs), 32'(e));
    end
  endtask

  // Monitor: compares scheduled samples and every new bus ownership against the queues.
  always @(negedge sclk) begin
    while (q_cyc.size() > 0 && q_cyc[0] <= cyc) begin
      chk(q_nm[0], act(q_sel[0]), q_val[0]);
      void'(q_nm.pop_front());
      void'(q_sel.pop_front());
      void'(q_cyc.pop_front());
      void'(q_val.pop_front());
    end
    if (aref_en && !prev_aref) pop_grant(-1);
    if (bus.ch_en != '0 && prev_chen == '0) pop_grant(owner_of(bus.ch_en));
    prev_aref <= aref_en;
    prev_chen <= bus.ch_en;
  end

  initial begin
    srst_n = 1'b0; init_end = 1'b0; aref_ask = 1'b0; aref_end = 1'b0;
    init_cmd = CMD_PRE; init_addr = 12'h400;
    aref_cmd = CMD_AREF; aref_addr = 12'h0A5;
    bus.ch_ask = '0; bus.ch_end = '0; bus.ch_dq_oe = '0;
    for (int i = 0; i < NCH; i++) begin
      bus.ch_cmd[i*4 +: 4]     = ch_cmd_tab[i];
      bus.ch_addr[i*AW +: AW]  = ch_addr_of(i);
      bus.ch_bank[i*BW +: BW]  = BW'(i);
      bus.ch_wdata[i*DW +: DW] = wd_of(i);
    end

    // Reset state: pins follow the init engine, nothing granted.
    step();
    expect_now("rst_cmd",  P_CMD,  32'(CMD_PRE));
    expect_now("rst_addr", P_ADDR, 32'(12'h400));
    expect_now("rst_chen", P_CHEN, 32'(0));
    expect_now("rst_aren", P_AREN, 32'(0));
    expect_now("rst_gid",  P_GID,  32'(0));
    expect_now("rst_misc", P_MISC, 32'(4'b1100));
    srst_n = 1'b1;

    for (int i = 0; i < 48; i++) begin
      step();
      init_cmd  = 4'(i);
      init_addr = AW'(i * 7);
      if (i % 8 == 0) begin
        expect_now("init_cmd",  P_CMD,  32'(init_cmd));
        expect_now("init_addr", P_ADDR, 32'(init_addr));
      end
    end
    step();
    init_end = 1'b1;
    expect_now("init_last", P_CMD, 32'(init_cmd));
    step();
    expect_now("arbit_cmd",  P_CMD,  32'(CMD_NOP));
    expect_now("arbit_addr", P_ADDR, 32'(0));
    expect_now("arbit_bank", P_BANK, 32'(0));

    // Single channel 0 burst with a write beat and a stray ch_end from channel 2.
    bus.ch_ask = 4'b0001;
    gq.push_back(0);
    expect_now("ask0_chen_pre", P_CHEN, 32'(0));
    step();
    bus.ch_ask = '0;
    expect_now("ch0_chen", P_CHEN, oh(0));
    expect_now("ch0_gid",  P_GID,  32'(0));
    expect_now("ch0_cmd",  P_CMD,  32'(ch_cmd_tab[0]));
    expect_now("ch0_addr", P_ADDR, 32'(ch_addr_of(0)));
    step();
    bus.ch_dq_oe = 4'b0001;
    bus.ch_end   = 4'b0100;
    expect_now("ch0_dq", P_RD, 32'(wd_of(0)));
    step();
    bus.ch_dq_oe = '0;
    bus.ch_end   = '0;
    expect_now("ch0_stray_end", P_CHEN, oh(0));
    for (int i = 0; i < 6; i++) step();
    bus.ch_end = 4'b0001;
    expect_now("ch0_last", P_CHEN, oh(0));
    step();
    bus.ch_end = '0;
    expect_now("ch0_done_cmd",  P_CMD,  32'(CMD_NOP));
    expect_now("ch0_done_chen", P_CHEN, 32'(0));

    // Refresh and channels ask together: refresh first, then channel 1.
    aref_ask = 1'b1;
    bus.ch_ask = 4'b1010;
    gq.push_back(-1);
    gq.push_back(1);
    expect_now("tie_aren_pre", P_AREN, 32'(0));
    step();
    aref_ask = 1'b0;
    expect_now("aref_aren", P_AREN, 32'(1));
    expect_now("aref_cmd",  P_CMD,  32'(CMD_AREF));
    expect_now("aref_addr", P_ADDR, 32'(12'h0A5));
    expect_now("aref_chen", P_CHEN, 32'(0));
    step();
    step();
    aref_end = 1'b1;
    step();
    aref_end = 1'b0;
    expect_now("aref_done_cmd",  P_CMD,  32'(CMD_NOP));
    expect_now("aref_done_aren", P_AREN, 32'(0));
    step();
    bus.ch_ask = '0;
    expect_now("ch1_chen", P_CHEN, oh(1));
    expect_now("ch1_gid",  P_GID,  32'(1));
    expect_now("ch1_bank", P_BANK, 32'(1));

    // Refresh request mid-burst: enable drops at once, state held until ch_end.
    step();
    aref_ask = 1'b1;
    gq.push_back(-1);
    expect_now("pre_chen", P_CHEN, 32'(0));
    expect_now("pre_cmd",  P_CMD,  32'(ch_cmd_tab[1]));
    step();
    bus.ch_end = 4'b0010;
    expect_now("pre_hold_cmd", P_CMD, 32'(ch_cmd_tab[1]));
    expect_now("pre_hold_aren", P_AREN, 32'(0));
    step();
    bus.ch_end = '0;
    expect_now("pre_arbit_cmd", P_CMD, 32'(CMD_NOP));
    step();
    aref_ask = 1'b0;
    expect_now("pre_aref_aren", P_AREN, 32'(1));
    step();
    aref_end = 1'b1;
    aref_ask = 1'b1;
    gq.push_back(-1);
    step();
    aref_end = 1'b0;
    expect_now("back2back_gap", P_AREN, 32'(0));
    step();
    aref_ask = 1'b0;
    expect_now("back2back_aren", P_AREN, 32'(1));
    step();
    aref_end = 1'b1;
    step();
    aref_end = 1'b0;
    expect_now("back2back_done", P_CMD, 32'(CMD_NOP));

    // All channels asking continuously: grant order depends on selection mode.
    bus.ch_ask = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      gq.push_back(rr_seq[g]);
      expect_now("all_arbit_chen", P_CHEN, 32'(0));
      step();
      expect_now("all_chen", P_CHEN, oh(rr_seq[g]));
      expect_now("all_gid",  P_GID,  32'(rr_seq[g]));
      bus.ch_end = NCH'(oh(rr_seq[g]));
      step();
      bus.ch_end = '0;
      expect_now("all_done_cmd", P_CMD, 32'(CMD_NOP));
    end
    bus.ch_ask = '0;

    // Asynchronous reset in the middle of a channel 2 write.
    bus.ch_ask = 4'b0100;
    gq.push_back(2);
    step();
    bus.ch_ask   = '0;
    bus.ch_dq_oe = 4'b0100;
    expect_now("ch2_dq",   P_RD,   32'(wd_of(2)));
    expect_now("ch2_chen", P_CHEN, oh(2));
    #6;
    srst_n = 1'b0;
    #1;
    chk("arst_chen", act(P_CHEN), 32'(0));
    chk("arst_aren", act(P_AREN), 32'(0));
    chk("arst_gid",  act(P_GID),  32'(0));
    chk("arst_cmd",  act(P_CMD),  32'(init_cmd));
    chk("arst_addr", act(P_ADDR), 32'(init_addr));
    step();
    srst_n = 1'b1;
    bus.ch_dq_oe = '0;
    expect_now("post_rst_cmd", P_CMD, 32'(init_cmd));
    step();
    expect_now("post_rst_arbit", P_CMD, 32'(CMD_NOP));
    step();
    step();
    chk("grant_drained", 32'(gq.size()), 32'(0));
    chk("samples_drained", 32'(q_cyc.size()), 32'(0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/sdram_arbiter.md
# sdram_arbiter

Parametrised SDRAM command arbiter and pin multiplexer; successor to the single-writer controller top. Sequences power-up init, then arbitrates the SDRAM bus between the auto-refresh engine and NUM_CH access engines (write/read bursts) over an ask/en/end handshake. Owns the SDRAM pins and the tri-state DQ bus. Refresh always pre-empts access engines at burst boundaries.

## Interface
- NUM_CH, 2: number of access-engine channels (1..8)
- ADDR_W, 12: SDRAM address width
- BANK_W, 2: bank address width
- DQ_W, 16: data bus width
- sclk  in  1  clock; sdram_clk = ~sclk
- srst_n  in  1  reset, asynchronous, active-low
- init_end  in  1  init engine done (level, stays high)
- init_cmd / init_addr  in  4 / ADDR_W  init engine command {cs_n,ras_n,cas_n,we_n} / address
- aref_ask  in  1  refresh engine requests bus
- aref_end  in  1  refresh sequence complete (1-cycle pulse)
- aref_cmd / aref_addr  in  4 / ADDR_W  refresh command / address
- aref_en  out  1  refresh engine owns bus
- ch_ask  in  NUM_CH  per-channel bus request
- ch_end  in  NUM_CH  per-channel burst complete (1-cycle pulse)
- ch_cmd / ch_addr / ch_bank  in  4·NUM_CH / ADDR_W·NUM_CH / BANK_W·NUM_CH  packed per-channel command fields, channel i at slice i
- ch_wdata  in  DQ_W·NUM_CH  per-channel write data
- ch_dq_oe  in  NUM_CH  channel i drives DQ this cycle
- ch_en  out  NUM_CH  channel i may issue commands
- rd_data  out  DQ_W  sdram_dq broadcast to all channels
- grant_id  out  $clog2(NUM_CH) (min 1)  current/last granted channel
- sdram_clk, sdram_cke, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n  out  1  SDRAM control
- sdram_bank / sdram_addr / sdram_dqm  out  BANK_W / ADDR_W / DQ_W/8
- sdram_dq  inout  DQ_W  data bus

## Operation
- States: S_INIT, S_ARBIT, S_AREF, S_ACCESS (one-hot).
- S_INIT -> S_ARBIT when init_end.
- S_ARBIT: aref_ask -> S_AREF; else any ch_ask -> S_ACCESS, grant_id <= selected channel; else stay.
- S_AREF -> S_ARBIT on aref_end.
- S_ACCESS -> S_ARBIT on ch_end[grant_id]; ch_end of non-granted channels ignored.
- aref_en = (state == S_AREF).
- ch_en[i] = (state == S_ACCESS) && (grant_id == i) && !aref_ask; engine finishes current burst, pulses ch_end, re-asks later.
- Pin mux (combinational): S_INIT -> init_cmd/init_addr, bank 0; S_AREF -> aref_cmd/aref_addr, bank 0; S_ACCESS -> ch_*[grant_id]; S_ARBIT -> NOP 4'b0111, addr 0, bank 0.
- sdram_dq = ch_wdata[grant_id] when S_ACCESS && ch_dq_oe[grant_id], else high-Z. rd_data = sdram_dq.
- sdram_cke = 1, sdram_dqm = 0.
- Selection: see Configuration. ch_ask sampled only in S_ARBIT.

## Timing
- Reset: state S_INIT, grant_id 0, ch_en 0, aref_en 0, DQ high-Z; pins follow init_cmd/init_addr.
- Arbitration: 1 cycle in S_ARBIT between any two owners; ask seen at edge k -> en high from edge k+1.
- Owner's end pulse at edge k -> S_ARBIT at k+1 (pins NOP), next owner at k+2.
- aref_ask during S_ACCESS drops ch_en same cycle (combinational); state held until ch_end.
- Simultaneous aref_ask and ch_ask in S_ARBIT: refresh wins.
- Simultaneous aref_end and new aref_ask: to S_ARBIT, then S_AREF again.
- srst_n mid-operation: immediate return to reset values, DQ released asynchronously.

## Configuration
- SDRAM_ARB_RR_EN defined: round-robin; search starts at grant_id+1 modulo NUM_CH, wraps; grant_id updates only on grant.
- Undefined: fixed priority, lowest asking index wins; starvation of high indices permitted.

## Structure
- Package sdram_pkg: state encodings, CMD_NOP/PRE/AREF/MRS/ACT/WR/RD 4-bit constants, ADDR_W/BANK_W/DQ_W defaults.
- One sub-module: sdram_rr_sel (ask vector + last grant -> valid + index), also housing fixed-priority mode under the macro.

## Test plan
- Reset, init_end at cycle 50 -> pins track init_cmd until cycle 50, S_ARBIT at 51, pins 4'b0111.
- ch_ask=2'b01, ch1 end after 10 cycles -> ch_en=01 one cycle after ask, DQ driven with ch_wdata[0] when ch_dq_oe[0], NOP cycle after ch_end.
- aref_ask=1 and ch_ask=2'b11 together in S_ARBIT -> aref_en first; channels granted after aref_end.
- aref_ask mid-burst on ch1 -> ch_en[1] low same cycle, state S_ACCESS until ch_end[1], then S_AREF after one S_ARBIT cycle.
- RR_EN, NUM_CH=4, ch_ask=4'b1111 held -> grants 1,2,3,0,1; without macro -> grants 0,0,0.
- srst_n low during S_ACCESS write -> DQ high-Z, ch_en 0, state S_INIT without clock edge.
